// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: two-stage valid/ready subtractor, diff = a + ~b + 1 via grouped CLA halves.
// The low half resolves in stage 1 and the upper half in stage 2 from the registered mid carry.
module pipelined_cla_subtractor #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int H = WIDTH / 2;

   // Returns {carry_out, sum}; each group expands its carries from the group carry-in.
   function automatic logic [H:0] cla(input logic [H-1:0] x, input logic [H-1:0] y, input logic cin);
      logic [H-1:0] g, p;
      logic [H:0]   c;
      logic         acc, pp;
      g = x & y;
      p = x ^ y;
      c = '0;
      c[0] = cin;
      for (int k = 0; k < H; k += GROUP) begin
         for (int j = 0; j < GROUP; j++) begin
            acc = g[k+j];
            pp  = p[k+j];
            for (int i = j - 1; i >= 0; i--) begin
               acc = acc | (pp & g[k+i]);
               pp  = pp & p[k+i];
            end
            c[k+j+1] = acc | (pp & c[k]);
         end
      end
      return {c[H], p ^ c[H-1:0]};
   endfunction

   logic [H-1:0]     lo_q, ahi_q, nbhi_q;
   logic             cmid_q, as_q, bs_q, s1v_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q, ovf_q, zero_q, ov_q;
   logic [H:0]       lo_d, hi_d;
   logic [WIDTH-1:0] diff_d;
   logic             s2_load, accept;

   always_comb begin
      s2_load  = !ov_q || out_ready;
      in_ready = !s1v_q || s2_load;
      accept   = in_valid && in_ready;
      lo_d     = cla(a[H-1:0], ~b[H-1:0], 1'b1);
      hi_d     = cla(ahi_q, nbhi_q, cmid_q);
      diff_d   = {hi_d[H-1:0], lo_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1v_q  <= 1'b0;
         lo_q   <= '0;
         ahi_q  <= '0;
         nbhi_q <= '0;
         cmid_q <= 1'b0;
         as_q   <= 1'b0;
         bs_q   <= 1'b0;
      end else if (accept) begin
         s1v_q  <= 1'b1;
         lo_q   <= lo_d[H-1:0];
         cmid_q <= lo_d[H];
         ahi_q  <= a[WIDTH-1:H];
         nbhi_q <= ~b[WIDTH-1:H];
         as_q   <= a[WIDTH-1];
         bs_q   <= b[WIDTH-1];
      end else if (s2_load) begin
         s1v_q  <= 1'b0;
      end
   end

   // Output fields only change on a load carrying real data, so they hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q   <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (s2_load) begin
         ov_q <= s1v_q;
         if (s1v_q) begin
            diff_q <= diff_d;
            bout_q <= ~hi_d[H];
            ovf_q  <= (as_q != bs_q) && (diff_d[WIDTH-1] != as_q);
            zero_q <= (diff_d == '0);
         end
      end
   end

   assign out_valid = ov_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule
